ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the neural-network pipeline processor. Sits directly downstream of the IF/EX pipeline register and consumes its decoded control and operand outputs. Evaluates the two chained ALUs (ALU1, then ALU2 on ALU1's result and Src1C), resolves the destination register, and registers the result into the EX/MEM boundary. Implements a multi-cycle iterative multiplier that stalls upstream stages while it runs.

## Interface
- BUS_WIDTH, 32, datapath width; must be a multiple of 4
- ALU_FUNCT_BITS, 3, width of ALU1/ALU2 function codes
- REGISTER, 6, register-specifier width

- CLK  in  1  clock, rising-edge
- RESET_N  in  1  asynchronous, active-low reset
- FlushE  in  1  synchronous flush of the instruction in EX
- RegWriteE, ALU1SrcE, RegDstE, MemWriteE, MemReadE, MemtoRegE  in  1 each  control from the IF/EX register
- ALU1CntrlE, ALU2CntrlE  in  ALU_FUNCT_BITS  ALU function codes
- Src1AE, Src1BE, Src1CE  in  BUS_WIDTH  register operands
- SignImmE  in  BUS_WIDTH  sign-extended immediate
- RtE, RdE  in  REGISTER  candidate destination registers
- StallE  out  1  hold request to upstream stages (combinational)
- RegWriteM, MemWriteM, MemReadM, MemtoRegM  out  1 each  registered control
- ALUOutM  out  BUS_WIDTH  registered ALU2 result
- WriteDataM  out  BUS_WIDTH  registered store data (Src1BE)
- WriteRegM  out  REGISTER  registered destination register

## Operation
- SrcB = ALU1SrcE ? SignImmE : Src1BE.
- ALU1 codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 1 or 0), 110 MUL (multi-cycle, low BUS_WIDTH bits of product), 111 PASS Src1AE.
- ALU2 codes, on R1 = ALU1 result: 000 PASS R1, 001 R1+Src1CE (accumulate), 010 R1-Src1CE, 011 signed max(R1,Src1CE), 100 ReLU: R1 if R1 ≥ 0 signed, else 0, 101 signed min(R1,Src1CE), 110/111 PASS R1.
- All add/sub/mul wrap modulo 2^BUS_WIDTH; no overflow flag.
- WriteReg = RegDstE ? RdE : RtE.
- Bubble = all four M control outputs 0; ALUOutM, WriteDataM and WriteRegM are don't-care but are driven to 0.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE, ALU1CntrlE = 110, no flush: latch Src1AE and SrcB, clear accumulator and counter, go to BUSY.
  - BUSY: each cycle, add multiplicand × low nibble of multiplier; shift multiplicand left 4 and multiplier right 4. After BUS_WIDTH/4 iterations (8 at default), go to DONE.
  - DONE: product drives R1; go to IDLE.
- StallE = (ALU1CntrlE = 110) AND state ≠ DONE AND NOT FlushE. Forced 0 while RESET_N is low.
- EX/MEM update on each edge:
  - FlushE = 1: load bubble.
  - Else StallE = 1: load bubble.
  - Else: load the computed instruction.
- FlushE in any state returns the FSM to IDLE and discards the partial product. Flush wins over stall and over DONE.
- Upstream holds its outputs stable while StallE is high. Operand changes during BUSY are ignored because operands are latched.

## Timing
- Non-MUL ops: one-cycle latency. Inputs in cycle n appear on M outputs after the rising edge ending cycle n.
- MUL, first seen in cycle 0:
  - StallE high in cycles 0-8; bubbles are emitted.
  - BUSY occupies cycles 1-8; DONE is cycle 9, with StallE low.
  - Result is on ALUOutM after the edge ending cycle 9. Total occupancy is 10 cycles.
- Back-to-back MULs: the second starts from IDLE in cycle 10. No idle gap is required between them.
- RESET_N low, asynchronous: all M outputs become 0, FSM goes to IDLE, counter and accumulator clear, effective immediately including mid-multiply. First operation is accepted in the cycle after RESET_N rises.

## Test plan
- Reset mid-MUL: assert RESET_N low during BUSY -> all M outputs 0 and StallE 0 immediately. After release, a MUL restarts with full 10-cycle latency.
- ADD chain: Src1A=5, SignImm=3, ALU1Src=1, ALU1=000, ALU2=001, Src1C=10, RegDst=1, Rd=7, RegWrite=1 -> next edge ALUOutM=18, WriteRegM=7, RegWriteM=1.
- ReLU and wrap:
  - SUB 2-5 with ALU2=100 -> ALUOutM=0.
  - ADD 0xFFFFFFFF+2 with ALU2=000 -> ALUOutM=1.
- MUL: Src1A=0x00012345, Src1B=0x00000100, ALU1=110, ALU2=001, Src1C=1 -> StallE high for exactly 9 cycles with bubbles. ALUOutM=0x01234501 after cycle 9. Also check signed -3×7 -> 0xFFFFFFEB.
- Flush mid-MUL: FlushE=1 in BUSY cycle 4 -> bubble loaded and FSM to IDLE. The MUL presented in the next cycle takes a fresh full 10 cycles.

Source files
------------

// File: rtl/ex_stage_if.sv
// Bundle between the IF/EX register, the execute stage and the EX/MEM boundary.
// The slave modport is the execute stage; the master is the surrounding pipeline.
interface ex_stage_if #(
  parameter int BUS_WIDTH      = 32,
  parameter int ALU_FUNCT_BITS = 3,
  parameter int REGISTER       = 6
);
  logic                      FlushE;
  logic                      RegWriteE;
  logic                      ALU1SrcE;
  logic                      RegDstE;
  logic                      MemWriteE;
  logic                      MemReadE;
  logic                      MemtoRegE;
  logic [ALU_FUNCT_BITS-1:0] ALU1CntrlE;
  logic [ALU_FUNCT_BITS-1:0] ALU2CntrlE;
  logic [BUS_WIDTH-1:0]      Src1AE;
  logic [BUS_WIDTH-1:0]      Src1BE;
  logic [BUS_WIDTH-1:0]      Src1CE;
  logic [BUS_WIDTH-1:0]      SignImmE;
  logic [REGISTER-1:0]       RtE;
  logic [REGISTER-1:0]       RdE;

  logic                      StallE;
  logic                      RegWriteM;
  logic                      MemWriteM;
  logic                      MemReadM;
  logic                      MemtoRegM;
  logic [BUS_WIDTH-1:0]      ALUOutM;
  logic [BUS_WIDTH-1:0]      WriteDataM;
  logic [REGISTER-1:0]       WriteRegM;

  modport master (
    output FlushE, RegWriteE, ALU1SrcE, RegDstE, MemWriteE, MemReadE, MemtoRegE,
    output ALU1CntrlE, ALU2CntrlE, Src1AE, Src1BE, Src1CE, SignImmE, RtE, RdE,
    input  StallE, RegWriteM, MemWriteM, MemReadM, MemtoRegM,
    input  ALUOutM, WriteDataM, WriteRegM
  );

  modport slave (
    input  FlushE, RegWriteE, ALU1SrcE, RegDstE, MemWriteE, MemReadE, MemtoRegE,
    input  ALU1CntrlE, ALU2CntrlE, Src1AE, Src1BE, Src1CE, SignImmE, RtE, RdE,
    output StallE, RegWriteM, MemWriteM, MemReadM, MemtoRegM,
    output ALUOutM, WriteDataM, WriteRegM
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: chained ALU1/ALU2 into the EX/MEM register, one-cycle latency.
// MUL runs a nibble-serial multiplier for 10 cycles, holding StallE and emitting bubbles.
module ex_stage #(
  parameter int BUS_WIDTH      = 32,
  parameter int ALU_FUNCT_BITS = 3,
  parameter int REGISTER       = 6
) (
  input logic      CLK,
  input logic      RESET_N,
  ex_stage_if.slave ex
);
  localparam int ITER  = BUS_WIDTH / 4;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  localparam logic [ALU_FUNCT_BITS-1:0] F1_ADD = ALU_FUNCT_BITS'(0);
  localparam logic [ALU_FUNCT_BITS-1:0] F1_SUB = ALU_FUNCT_BITS'(1);
  localparam logic [ALU_FUNCT_BITS-1:0] F1_AND = ALU_FUNCT_BITS'(2);
  localparam logic [ALU_FUNCT_BITS-1:0] F1_OR  = ALU_FUNCT_BITS'(3);
  localparam logic [ALU_FUNCT_BITS-1:0] F1_XOR = ALU_FUNCT_BITS'(4);
  localparam logic [ALU_FUNCT_BITS-1:0] F1_SLT = ALU_FUNCT_BITS'(5);
  localparam logic [ALU_FUNCT_BITS-1:0] F1_MUL = ALU_FUNCT_BITS'(6);

  localparam logic [ALU_FUNCT_BITS-1:0] F2_ACC  = ALU_FUNCT_BITS'(1);
  localparam logic [ALU_FUNCT_BITS-1:0] F2_SUB  = ALU_FUNCT_BITS'(2);
  localparam logic [ALU_FUNCT_BITS-1:0] F2_MAX  = ALU_FUNCT_BITS'(3);
  localparam logic [ALU_FUNCT_BITS-1:0] F2_RELU = ALU_FUNCT_BITS'(4);
  localparam logic [ALU_FUNCT_BITS-1:0] F2_MIN  = ALU_FUNCT_BITS'(5);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  mul_state_e           state_q, state_d;
  logic [BUS_WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 is_mul;
  logic                 stall;
  logic [BUS_WIDTH-1:0] srcb;
  logic [BUS_WIDTH-1:0] partial;
  logic [BUS_WIDTH-1:0] r1;
  logic [BUS_WIDTH-1:0] r2;
  logic [REGISTER-1:0]  write_reg;

  assign is_mul    = (ex.ALU1CntrlE == F1_MUL);
  assign srcb      = ex.ALU1SrcE ? ex.SignImmE : ex.Src1BE;
  assign write_reg = ex.RegDstE ? ex.RdE : ex.RtE;
  assign partial   = mcand_q * {{(BUS_WIDTH-4){1'b0}}, mplier_q[3:0]};
  // Held low during reset so upstream is never frozen by a stale opcode.
  assign stall     = RESET_N && is_mul && (state_q != DONE) && !ex.FlushE;
  assign ex.StallE = stall;

  always_comb begin
    r1 = '0;
    case (ex.ALU1CntrlE)
      F1_ADD:  r1 = ex.Src1AE + srcb;
      F1_SUB:  r1 = ex.Src1AE - srcb;
      F1_AND:  r1 = ex.Src1AE & srcb;
      F1_OR:   r1 = ex.Src1AE | srcb;
      F1_XOR:  r1 = ex.Src1AE ^ srcb;
      F1_SLT:  r1 = {{(BUS_WIDTH-1){1'b0}}, ($signed(ex.Src1AE) < $signed(srcb))};
      F1_MUL:  r1 = acc_q;
      default: r1 = ex.Src1AE;
    endcase
  end

  always_comb begin
    r2 = r1;
    case (ex.ALU2CntrlE)
      F2_ACC:  r2 = r1 + ex.Src1CE;
      F2_SUB:  r2 = r1 - ex.Src1CE;
      F2_MAX:  r2 = ($signed(r1) > $signed(ex.Src1CE)) ? r1 : ex.Src1CE;
      F2_RELU: r2 = r1[BUS_WIDTH-1] ? '0 : r1;
      F2_MIN:  r2 = ($signed(r1) < $signed(ex.Src1CE)) ? r1 : ex.Src1CE;
      default: r2 = r1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_mul) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_ITER) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (ex.FlushE) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operands are latched at start, so upstream changes during BUSY are harmless.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (ex.FlushE) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (is_mul) begin
          mcand_q  <= ex.Src1AE;
          mplier_q <= srcb;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        BUSY: begin
          acc_q    <= acc_q + partial;
          mcand_q  <= mcand_q << 4;
          mplier_q <= mplier_q >> 4;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ex.RegWriteM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
      ex.MemReadM   <= 1'b0;
      ex.MemtoRegM  <= 1'b0;
      ex.ALUOutM    <= '0;
      ex.WriteDataM <= '0;
      ex.WriteRegM  <= '0;
    end else if (ex.FlushE || stall) begin
      ex.RegWriteM  <= 1'b0;
      ex.MemWriteM  <= 1'b0;
      ex.MemReadM   <= 1'b0;
      ex.MemtoRegM  <= 1'b0;
      ex.ALUOutM    <= '0;
      ex.WriteDataM <= '0;
      ex.WriteRegM  <= '0;
    end else begin
      ex.RegWriteM  <= ex.RegWriteE;
      ex.MemWriteM  <= ex.MemWriteE;
      ex.MemReadM   <= ex.MemReadE;
      ex.MemtoRegM  <= ex.MemtoRegE;
      ex.ALUOutM    <= r2;
      ex.WriteDataM <= ex.Src1BE;
      ex.WriteRegM  <= write_reg;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized ops against a plain-arithmetic model.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if ifc ();
  ex_stage dut (.CLK(clk), .RESET_N(rst_n), .ex(ifc));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic flush, rw, a1src, rdst, mw, mr, mtr;
    logic [2:0] f1, f2;
    logic [31:0] a, b, c, imm;
    logic [5:0] rt, rd;
  } op_t;

  typedef struct packed {
    logic rw, mw, mr, mtr;
    logic [31:0] alu, wd;
    logic [5:0] wr;
  } mout_t;

  localparam mout_t BUBBLE = '0;

  function automatic op_t mk(input logic [2:0] f1, input logic [2:0] f2,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic a1src,
                             input logic [31:0] imm);
    op_t o;
    o = '0;
    o.rw = 1'b1; o.rdst = 1'b1; o.rt = 6'd3; o.rd = 6'd9;
    o.f1 = f1; o.f2 = f2; o.a = a; o.b = b; o.c = c; o.a1src = a1src; o.imm = imm;
    return o;
  endfunction

  function automatic op_t rand_op(input bit mul);
    op_t o;
    o.flush = 1'b0;
    o.rw = 1'($urandom); o.a1src = 1'($urandom); o.rdst = 1'($urandom);
    o.mw = 1'($urandom); o.mr = 1'($urandom); o.mtr = 1'($urandom);
    o.f1 = mul ? 3'd6 : 3'($urandom_range(0, 7));
    if (!mul && o.f1 == 3'd6) o.f1 = 3'd7;
    o.f2 = 3'($urandom_range(0, 7));
    o.a = $urandom; o.b = $urandom; o.c = $urandom; o.imm = $urandom;
    o.rt = 6'($urandom); o.rd = 6'($urandom);
    return o;
  endfunction

  // Reference: what the EX/MEM register should hold for a completed instruction.
  function automatic mout_t model(input op_t o);
    mout_t m;
    int signed sa, sb, sr1, sc;
    logic [31:0] srcb, r1, r2;
    srcb = o.a1src ? o.imm : o.b;
    sa = o.a; sb = srcb; sc = o.c;
    case (o.f1)
      3'd0: r1 = o.a + srcb;
      3'd1: r1 = o.a - srcb;
      3'd2: r1 = o.a & srcb;
      3'd3: r1 = o.a | srcb;
      3'd4: r1 = o.a ^ srcb;
      3'd5: r1 = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r1 = o.a * srcb;
      default: r1 = o.a;
    endcase
    sr1 = r1;
    case (o.f2)
      3'd1: r2 = r1 + o.c;
      3'd2: r2 = r1 - o.c;
      3'd3: r2 = (sr1 > sc) ? r1 : o.c;
      3'd4: r2 = (sr1 < 0) ? 32'd0 : r1;
      3'd5: r2 = (sr1 < sc) ? r1 : o.c;
      default: r2 = r1;
    endcase
    m.rw = o.rw; m.mw = o.mw; m.mr = o.mr; m.mtr = o.mtr;
    m.alu = r2; m.wd = o.b; m.wr = o.rdst ? o.rd : o.rt;
    return m;
  endfunction

  function automatic mout_t observed();
    mout_t m;
    m.rw = ifc.RegWriteM; m.mw = ifc.MemWriteM; m.mr = ifc.MemReadM; m.mtr = ifc.MemtoRegM;
    m.alu = ifc.ALUOutM; m.wd = ifc.WriteDataM; m.wr = ifc.WriteRegM;
    return m;
  endfunction

  task automatic apply(input op_t o);
    ifc.FlushE = o.flush; ifc.RegWriteE = o.rw; ifc.ALU1SrcE = o.a1src; ifc.RegDstE = o.rdst;
    ifc.MemWriteE = o.mw; ifc.MemReadE = o.mr; ifc.MemtoRegE = o.mtr;
    ifc.ALU1CntrlE = o.f1; ifc.ALU2CntrlE = o.f2;
    ifc.Src1AE = o.a; ifc.Src1BE = o.b; ifc.Src1CE = o.c; ifc.SignImmE = o.imm;
    ifc.RtE = o.rt; ifc.RdE = o.rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a MUL in the current cycle (cycle 0); presents nxt in cycle 10.
  task automatic run_mul(input op_t o, input op_t nxt, input string nm, output mout_t res);
    int stalls;
    stalls = 0;
    apply(o);
    for (int k = 0; k < 10; k++) begin
      #1;
      if (ifc.StallE) stalls++;
      checks++;
      if (ifc.StallE !== (k < 9)) begin
        errors++;
        $display("FAIL %s stall cycle %0d: got %b want %b", nm, k, ifc.StallE, (k < 9));
      end
      tick();
      if (k < 9) begin
        checks++;
        if (observed() !== BUBBLE) begin
          errors++;
          $display("FAIL %s bubble cycle %0d: got %h want %h", nm, k, observed(), BUBBLE);
        end
      end
    end
    res = observed();
    checks++;
    if (res !== model(o)) begin
      errors++;
      $display("FAIL %s result: got %h want %h", nm, res, model(o));
    end
    apply(nxt);
    checks++;
    if (stalls != 9) begin
      errors++;
      $display("FAIL %s stall count: got %0d want 9", nm, stalls);
    end
  endtask

  op_t nop;

  task automatic test_reset();
    apply(mk(3'd6, 3'd0, 32'd9, 32'd9, 32'd0, 1'b0, 32'd0));
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.StallE !== 1'b0 || observed() !== BUBBLE) begin
      errors++;
      $display("FAIL reset_state: got stall=%b m=%h want stall=0 m=0", ifc.StallE, observed());
    end
    tick(); tick();
    checks++;
    if (ifc.StallE !== 1'b0 || observed() !== BUBBLE) begin
      errors++;
      $display("FAIL reset_hold: got stall=%b m=%h want stall=0 m=0", ifc.StallE, observed());
    end
    apply(nop);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_chain();
    op_t o;
    o = mk(3'd0, 3'd1, 32'd5, 32'd0, 32'd10, 1'b1, 32'd3);
    o.rd = 6'd7;
    apply(o);
    tick();
    checks++;
    if (ifc.ALUOutM !== 32'd18 || ifc.WriteRegM !== 6'd7 || ifc.RegWriteM !== 1'b1) begin
      errors++;
      $display("FAIL add_chain: got alu=%h wr=%0d rw=%b want alu=00000012 wr=7 rw=1",
               ifc.ALUOutM, ifc.WriteRegM, ifc.RegWriteM);
    end
  endtask

  task automatic test_relu_wrap();
    apply(mk(3'd1, 3'd4, 32'd2, 32'd5, 32'd0, 1'b0, 32'd0));
    tick();
    checks++;
    if (ifc.ALUOutM !== 32'd0) begin
      errors++;
      $display("FAIL relu: got %h want 00000000", ifc.ALUOutM);
    end
    apply(mk(3'd0, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 32'd0));
    tick();
    checks++;
    if (ifc.ALUOutM !== 32'd1) begin
      errors++;
      $display("FAIL wrap: got %h want 00000001", ifc.ALUOutM);
    end
  endtask

  task automatic test_mul();
    mout_t r;
    run_mul(mk(3'd6, 3'd1, 32'h0001_2345, 32'h0000_0100, 32'd1, 1'b0, 32'd0), nop, "mul", r);
    checks++;
    if (r.alu !== 32'h0123_4501) begin
      errors++;
      $display("FAIL mul_value: got %h want 01234501", r.alu);
    end
    tick();
    run_mul(mk(3'd6, 3'd0, 32'hFFFF_FFFD, 32'd7, 32'd0, 1'b0, 32'd0), nop, "mul_signed", r);
    checks++;
    if (r.alu !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL mul_signed_value: got %h want ffffffeb", r.alu);
    end
    tick();
  endtask

  task automatic test_flush();
    op_t m;
    mout_t r;
    m = mk(3'd6, 3'd2, 32'h0000_1234, 32'h0000_0056, 32'd100, 1'b0, 32'd0);
    apply(m);
    for (int k = 0; k < 4; k++) tick();
    ifc.FlushE = 1'b1;
    #1;
    checks++;
    if (ifc.StallE !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b want 0", ifc.StallE);
    end
    tick();
    checks++;
    if (observed() !== BUBBLE) begin
      errors++;
      $display("FAIL flush_bubble: got %h want %h", observed(), BUBBLE);
    end
    run_mul(m, m, "mul_after_flush", r);
    // Flush landing on DONE must drop the finished product.
    for (int k = 0; k < 9; k++) tick();
    ifc.FlushE = 1'b1;
    tick();
    checks++;
    if (observed() !== BUBBLE) begin
      errors++;
      $display("FAIL flush_done: got %h want %h", observed(), BUBBLE);
    end
    apply(nop);
    tick();
    checks++;
    if (observed() !== model(nop)) begin
      errors++;
      $display("FAIL after_flush_done: got %h want %h", observed(), model(nop));
    end
  endtask

  task automatic test_reset_mid_mul();
    op_t m, a;
    mout_t r;
    a = mk(3'd3, 3'd0, 32'h00F0_0000, 32'h0000_000F, 32'd0, 1'b0, 32'd0);
    apply(a);
    tick();
    m = mk(3'd6, 3'd0, 32'h0000_0ABC, 32'h0000_0123, 32'd0, 1'b0, 32'd0);
    apply(m);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== BUBBLE || ifc.StallE !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got m=%h stall=%b want m=0 stall=0", observed(), ifc.StallE);
    end
    rst_n = 1'b1;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== BUBBLE || ifc.StallE !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: got m=%h stall=%b want m=0 stall=0", observed(), ifc.StallE);
    end
    tick();
    apply(nop);
    rst_n = 1'b1;
    tick();
    run_mul(m, nop, "mul_after_reset", r);
    tick();
  endtask

  task automatic test_back_to_back();
    op_t m1, m2;
    mout_t r;
    m1 = mk(3'd6, 3'd5, 32'h8000_0003, 32'h0000_0011, 32'h0000_0040, 1'b0, 32'd0);
    m2 = mk(3'd6, 3'd3, 32'h0000_0007, 32'd0, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFFE);
    run_mul(m1, m2, "b2b_first", r);
    run_mul(m2, nop, "b2b_second", r);
    tick();
  endtask

  task automatic test_random();
    op_t o;
    mout_t exp;
    mout_t r;
    for (int i = 0; i < 300; i++) begin
      o = rand_op(1'b0);
      o.flush = ($urandom_range(0, 9) == 0);
      apply(o);
      #1;
      checks++;
      if (ifc.StallE !== 1'b0) begin
        errors++;
        $display("FAIL rand_stall %0d: got %b want 0", i, ifc.StallE);
      end
      exp = o.flush ? BUBBLE : model(o);
      tick();
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL rand_op %0d: got %h want %h", i, observed(), exp);
      end
    end
    for (int i = 0; i < 5; i++) begin
      run_mul(rand_op(1'b1), nop, "rand_mul", r);
      tick();
    end
  endtask

  initial begin
    nop = mk(3'd0, 3'd0, 32'd1, 32'd2, 32'd0, 1'b0, 32'd0);
    nop.rw = 1'b0;
    apply(nop);
    test_reset();
    test_add_chain();
    test_relu_wrap();
    test_mul();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
